hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard and forwarding controller for the ARM pipeline. It is the next generation of the separate hazard-detection and forwarding units. It tracks every in-flight register writer in an internal shift-register scoreboard, with no taps on downstream stage registers. For the instruction in ID it decides each cycle between stall and issue. For each issued instruction it produces registered operand-select codes for the EXE-stage operand muxes. Pipeline depth, load-data latency and register-address width are generic, and forwarding can be turned off at run time.

## Interface
- REG_ADDR_W, 4: register-address width.
- DEPTH, 3: number of post-ID stages tracked (1 = EXE, 2 = MEM, 3 = WB). Must be ≥ 2.
- LOAD_READY_STAGE, 3: first stage whose load data can be forwarded. Range 2..DEPTH.
- CNT_W, 16: stall-counter width.
- SEL_W, $clog2(DEPTH+1): derived select width.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- forward  in  1  1 = forwarding mode, 0 = stall-only mode.
- issue_valid  in  1  valid instruction in ID.
- issue_wb_en  in  1  the ID instruction writes a register.
- issue_mem_read  in  1  the ID instruction is a load.
- issue_dest  in  REG_ADDR_W  destination register of the ID instruction.
- id_src1, id_src2  in  REG_ADDR_W  source registers.
- id_src1_used, id_two_src  in  1  qualify src1 and src2 respectively.
- flush  in  1  branch taken; the ID instruction must not issue.
- stat_clr  in  1  synchronous clear of stall_count.
- stall  out  1  combinational; freezes PC and IF/ID.
- sel_src1, sel_src2  out  SEL_W  registered; 0 = register-file value, k = result held at stage k.
- stall_count  out  CNT_W  saturating count of stall cycles.

## Operation
- **Scoreboard.** Entries e[1..DEPTH], each holding {valid, wb_en, mem_read, dest}.
  - Every cycle unconditionally: e[k+1] <= e[k]; e[DEPTH] retires.
  - e[1] <= ID instruction if issue = issue_valid & ~stall & ~flush; otherwise e[1] <= bubble (valid = 0).
- **Match.** Source s matches entry k when all of these hold: e[k].valid, e[k].wb_en, e[k].dest == s, and s is qualified by its used flag.
  - Entry DEPTH never matches: the register-file write at WB is visible to the ID read in the same cycle.
- **Forwarding mode (forward = 1).** For each qualified source, take the youngest matching k (smallest k). Its data will be at stage k+1 during the consumer's EXE cycle.
  - If e[k].mem_read and k+1 < LOAD_READY_STAGE, the source is not ready and raises the hazard.
  - Otherwise the pending select for that source = k+1.
  - No match gives a pending select of 0.
- **Stall-only mode (forward = 0).** Any match raises the hazard, and all pending selects are 0.
- **stall** = issue_valid & hazard(src1 | src2). stall is not masked by flush; the flush input still blocks issue.
- **Select registers.**
  - On issue, sel_src1 and sel_src2 <= pending selects.
  - Otherwise (stall, flush or no valid instruction) they <= 0, matching the bubble now in EXE.
- **stall_count.**
  - Increments when stall & ~flush.
  - Saturates at 2^CNT_W−1.
  - stat_clr has priority over increment.
- A change of forward takes effect in the same cycle's hazard and select evaluation.

## Timing
- Reset (rst = 0, asynchronous): all entries invalid, sel_src1 = sel_src2 = 0, stall_count = 0. stall = 0 follows combinationally because no entry is valid.
- Reset asserted mid-operation discards all in-flight entries. The first cycle after release behaves as if the pipeline were empty.
- Latency:
  - stall: 0 cycles, combinational from the inputs and the scoreboard.
  - sel: registered, valid during the consumer's EXE cycle (1 cycle after issue).
- Forwarding-mode stall length for a producer k stages ahead:
  - ALU producer: 0 cycles.
  - Load producer: max(0, LOAD_READY_STAGE − 1 − k) cycles.
- Stall-only stall length: DEPTH − k cycles.
- flush together with a hazard: no issue, bubble inserted, stall_count not incremented.

## Test plan
- Reset: run traffic, drive rst = 0 mid-stream → sel_src1 = sel_src2 = 0, stall = 0 and stall_count = 0 immediately; after release a src1 = 3 consumer issues with sel_src1 = 0.
- ALU back-to-back, forward = 1: issue wb_en dest = 3, then the next cycle src1 = 3 → stall = 0, and sel_src1 = 2 one cycle later. With one independent instruction in between → sel_src1 = 3.
- Load-use: load dest = 5, next consumer src2 = 5 with id_two_src = 1 → stall = 1 for exactly 1 cycle, then issue with sel_src2 = 3; stall_count = 1.
- Stall-only: forward = 0, ALU dest = 3, next consumer src1 = 3 → stall for 2 cycles, then issue with sel_src1 = 0; stall_count = 2.
- Youngest wins: two writers to r4 issued back-to-back, then consumer src1 = 4 → sel_src1 = 2 (younger writer), not 3. With id_src1_used = 0 → sel_src1 = 0.
- Flush: flush = 1 while a load-use hazard is pending → no issue, sel = 0, stall_count unchanged. Drive stall_count to 2^CNT_W−1 → it holds; stat_clr → 0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//
// Combined hazard-detection and forwarding controller. The controller keeps
// its own shift-register scoreboard of in-flight register writers. It does
// not tap the downstream pipeline registers.
//
// Each cycle it decides whether the instruction in ID must stall or may issue.
// For every issued instruction it registers the operand-select codes that the
// EXE-stage operand muxes use in the following cycle.
//
// Parameters
//   REG_ADDR_W        register-address width
//   DEPTH             post-ID stages tracked (1 = EXE ... DEPTH = WB), >= 2
//   LOAD_READY_STAGE  first stage whose load data can be forwarded, 2..DEPTH
//   CNT_W             stall-counter width
//   SEL_W             select-code width, derived
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous active-low reset
//   forward         1 = forwarding mode, 0 = stall-only mode
//   issue_valid     valid instruction in ID
//   issue_wb_en     ID instruction writes a register
//   issue_mem_read  ID instruction is a load
//   issue_dest      ID destination register
//   id_src1/2       ID source registers
//   id_src1_used    qualifies id_src1
//   id_two_src      qualifies id_src2
//   flush           taken branch; the ID instruction must not issue
//   stat_clr        synchronous clear of stall_count
//   stall           combinational; freezes PC and IF/ID
//   sel_src1/2      registered EXE operand selects (0 = regfile, k = stage k)
//   stall_count     saturating count of stall cycles
//
// Handshake: issue_valid is the ID "valid" and ~stall is the "ready". An
// instruction transfers into EXE in a cycle where issue_valid & ~stall & ~flush
// holds. A flush drops the instruction rather than holding it, so flush is not
// part of ready.
module hazard_scoreboard #(
  parameter int REG_ADDR_W       = 4,
  parameter int DEPTH            = 3,
  parameter int LOAD_READY_STAGE = 3,
  parameter int CNT_W            = 16,
  parameter int SEL_W            = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  forward,
  input  logic                  issue_valid,
  input  logic                  issue_wb_en,
  input  logic                  issue_mem_read,
  input  logic [REG_ADDR_W-1:0] issue_dest,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_src1_used,
  input  logic                  id_two_src,
  input  logic                  flush,
  input  logic                  stat_clr,
  output logic                  stall,
  output logic [SEL_W-1:0]      sel_src1,
  output logic [SEL_W-1:0]      sel_src2,
  output logic [CNT_W-1:0]      stall_count
);

  // Entry DEPTH (WB) writes the register file in the same cycle that ID reads
  // it, so that entry can never cause a hazard or a forward. Only entries
  // 1..DEPTH-1 are stored. An instruction shifting out of DEPTH-1 simply retires.
  localparam int LAST = DEPTH - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [LAST:1]         r_valid;
  logic [LAST:1]         r_wb_en;
  logic [LAST:1]         r_mem_read;
  logic [REG_ADDR_W-1:0] r_dest [1:LAST];

  logic [SEL_W-1:0]      r_sel_src1;
  logic [SEL_W-1:0]      r_sel_src2;
  logic [CNT_W-1:0]      r_stall_count;

  logic [REG_ADDR_W-1:0] w_src       [2];
  logic [1:0]            w_used;
  logic [1:0]            w_hit;
  logic [1:0]            w_not_ready;
  logic [SEL_W-1:0]      w_match_sel [2];
  logic [SEL_W-1:0]      w_pend_sel  [2];
  logic [1:0]            w_hazard;
  logic                  w_stall;
  logic                  w_issue;

  always_comb begin
    w_src[0] = id_src1;
    w_src[1] = id_src2;
    w_used   = {id_two_src, id_src1_used};
  end

  // Per-source match. The scan runs from oldest to youngest, so the last hit
  // wins and the youngest matching writer decides the select and readiness.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      w_hit[s]       = 1'b0;
      w_not_ready[s] = 1'b0;
      w_match_sel[s] = '0;
      for (int k = LAST; k >= 1; k--) begin
        if (w_used[s] && r_valid[k] && r_wb_en[k] && (r_dest[k] == w_src[s])) begin
          w_hit[s]       = 1'b1;
          // Data sits at stage k+1 when the consumer reaches EXE.
          w_match_sel[s] = SEL_W'(k + 1);
          w_not_ready[s] = r_mem_read[k] && ((k + 1) < LOAD_READY_STAGE);
        end
      end
      if (forward) begin
        w_hazard[s]   = w_not_ready[s];
        w_pend_sel[s] = w_match_sel[s];
      end else begin
        w_hazard[s]   = w_hit[s];
        w_pend_sel[s] = '0;
      end
    end
  end

  // stall is deliberately not masked by flush. Flush only blocks issue.
  assign w_stall = issue_valid & (|w_hazard);
  assign w_issue = issue_valid & ~w_stall & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid    <= '0;
      r_wb_en    <= '0;
      r_mem_read <= '0;
      for (int k = 1; k <= LAST; k++) r_dest[k] <= '0;
    end else begin
      // A cycle without issue puts a bubble (valid = 0) into EXE.
      r_valid[1]    <= w_issue;
      r_wb_en[1]    <= issue_wb_en;
      r_mem_read[1] <= issue_mem_read;
      r_dest[1]     <= issue_dest;
      for (int k = 2; k <= LAST; k++) begin
        r_valid[k]    <= r_valid[k-1];
        r_wb_en[k]    <= r_wb_en[k-1];
        r_mem_read[k] <= r_mem_read[k-1];
        r_dest[k]     <= r_dest[k-1];
      end
    end
  end

  // The selects follow the instruction into EXE. A bubble selects the regfile.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sel_src1 <= '0;
      r_sel_src2 <= '0;
    end else begin
      r_sel_src1 <= w_issue ? w_pend_sel[0] : '0;
      r_sel_src2 <= w_issue ? w_pend_sel[1] : '0;
    end
  end

  // A stall cycle that is also flushed is not counted, because the slot is
  // being discarded anyway.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_count <= '0;
    end else if (stat_clr) begin
      r_stall_count <= '0;
    end else if (w_stall && !flush && (r_stall_count != CNT_MAX)) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign stall       = w_stall;
  assign sel_src1    = r_sel_src1;
  assign sel_src2    = r_sel_src2;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard.
//
// The reference model keeps a list of issued instructions stamped with their
// issue cycle. An instruction's pipeline stage is its age (the current cycle
// minus the stamp). Hazards and selects are derived from those ages.
module tb_hazard_scoreboard;

  localparam int RW      = 4;
  localparam int DEPTH   = 3;
  localparam int LRS     = 3;
  localparam int CNT_W   = 5;
  localparam int SEL_W   = $clog2(DEPTH + 1);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // clock / reset and DUT signals
  logic             clk;
  logic             rst;
  logic             forward;
  logic             issue_valid;
  logic             issue_wb_en;
  logic             issue_mem_read;
  logic [RW-1:0]    issue_dest;
  logic [RW-1:0]    id_src1;
  logic [RW-1:0]    id_src2;
  logic             id_src1_used;
  logic             id_two_src;
  logic             flush;
  logic             stat_clr;
  logic             stall;
  logic [SEL_W-1:0] sel_src1;
  logic [SEL_W-1:0] sel_src2;
  logic [CNT_W-1:0] stall_count;

  hazard_scoreboard #(
    .REG_ADDR_W       (RW),
    .DEPTH            (DEPTH),
    .LOAD_READY_STAGE (LRS),
    .CNT_W            (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .forward        (forward),
    .issue_valid    (issue_valid),
    .issue_wb_en    (issue_wb_en),
    .issue_mem_read (issue_mem_read),
    .issue_dest     (issue_dest),
    .id_src1        (id_src1),
    .id_src2        (id_src2),
    .id_src1_used   (id_src1_used),
    .id_two_src     (id_two_src),
    .flush          (flush),
    .stat_clr       (stat_clr),
    .stall          (stall),
    .sel_src1       (sel_src1),
    .sel_src2       (sel_src2),
    .stall_count    (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  typedef struct {
    int t;
    bit wb;
    bit mem;
    int dest;
  } rec_t;

  rec_t inflight[$];
  int   now;
  int   exp_sel1;
  int   exp_sel2;
  int   exp_cnt;
  bit   last_stall;

  int   n_tests;
  int   n_fail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    inflight.delete();
    now      = 0;
    exp_sel1 = 0;
    exp_sel2 = 0;
    exp_cnt  = 0;
  endfunction

  // Find the youngest writer of s still ahead of WB and derive hazard/select.
  function automatic void resolve(input int s, input bit used, output bit haz, output int sel);
    int best;
    bit best_mem;
    best     = 0;
    best_mem = 1'b0;
    haz      = 1'b0;
    sel      = 0;
    foreach (inflight[i]) begin
      int age;
      age = now - inflight[i].t;
      if (used && inflight[i].wb && inflight[i].dest == s && age >= 1 && age <= DEPTH - 1 &&
          (best == 0 || age < best)) begin
        best     = age;
        best_mem = inflight[i].mem;
      end
    end
    if (best != 0) begin
      if (!forward)                      haz = 1'b1;
      else if (best_mem && best + 1 < LRS) haz = 1'b1;
      else                               sel = best + 1;
    end
  endfunction

  // driver: one clock cycle, entered and left at a falling edge
  task automatic step(input bit v, input bit wb, input bit mem, input int dest,
                      input int s1, input bit u1, input int s2, input bit u2,
                      input bit fl, input bit clr);
    bit h1, h2, exp_stall, iss;
    int p1, p2;
    issue_valid    = v;
    issue_wb_en    = wb;
    issue_mem_read = mem;
    issue_dest     = RW'(dest);
    id_src1        = RW'(s1);
    id_src1_used   = u1;
    id_src2        = RW'(s2);
    id_two_src     = u2;
    flush          = fl;
    stat_clr       = clr;
    #1;
    resolve(s1, u1, h1, p1);
    resolve(s2, u2, h2, p2);
    exp_stall = v && (h1 || h2);
    check_eq("stall", stall, exp_stall);
    last_stall = stall;
    @(posedge clk);
    iss = v && !exp_stall && !fl;
    if (iss) inflight.push_back('{t: now, wb: wb, mem: mem, dest: dest});
    now++;
    while (inflight.size() > 0 && now - inflight[0].t > DEPTH) void'(inflight.pop_front());
    exp_sel1 = iss ? p1 : 0;
    exp_sel2 = iss ? p2 : 0;
    if (clr) exp_cnt = 0;
    else if (exp_stall && !fl && exp_cnt < CNT_MAX) exp_cnt++;
    #1;
    check_eq("sel_src1", sel_src1, exp_sel1);
    check_eq("sel_src2", sel_src2, exp_sel2);
    check_eq("stall_count", stall_count, exp_cnt);
    @(negedge clk);
  endtask

  task automatic nop(input bit clr);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, clr);
  endtask

  task automatic drain();
    repeat (DEPTH) nop(0);
  endtask

  // Hold a consumer in ID until it issues. Returns the stall cycles seen.
  task automatic consume(input int s1, input bit u1, input int s2, input bit u2, output int nstall);
    nstall = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, 0, s1, u1, s2, u2, 0, 0);
      if (!last_stall) return;
      nstall++;
    end
  endtask

  initial begin
    int ns;
    bit hold;
    int r_dest_v, r_s1, r_s2;
    bit r_v, r_wb, r_mem, r_u1, r_u2, r_fl, r_clr;

    n_tests = 0;
    n_fail  = 0;
    model_reset();
    forward = 1'b1;
    rst     = 1'b0;
    issue_valid = 1'b1; issue_wb_en = 1'b0; issue_mem_read = 1'b0; issue_dest = '0;
    id_src1 = '0; id_src2 = '0; id_src1_used = 1'b1; id_two_src = 1'b1;
    flush = 1'b0; stat_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_stall", stall, 0);
    check_eq("reset_sel1", sel_src1, 0);
    check_eq("reset_sel2", sel_src2, 0);
    check_eq("reset_cnt", stall_count, 0);
    @(negedge clk);
    rst = 1'b1;

    // ALU back-to-back
    step(1, 1, 0, 3, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 3, 1, 0, 0, 0, 0);
    check_eq("alu_b2b_stall", last_stall, 0);
    check_eq("alu_b2b_sel1", sel_src1, 2);
    drain();
    step(1, 1, 0, 3, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 7, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 3, 1, 0, 0, 0, 0);
    check_eq("alu_gap_sel1", sel_src1, 3);

    // load-use
    drain();
    nop(1);
    step(1, 1, 1, 5, 0, 0, 0, 0, 0, 0);
    consume(0, 0, 5, 1, ns);
    check_eq("load_use_stalls", ns, 1);
    check_eq("load_use_sel2", sel_src2, 3);
    check_eq("load_use_cnt", stall_count, 1);

    // stall-only
    drain();
    nop(1);
    forward = 1'b0;
    step(1, 1, 0, 3, 0, 0, 0, 0, 0, 0);
    consume(3, 1, 0, 0, ns);
    check_eq("stall_only_stalls", ns, 2);
    check_eq("stall_only_sel1", sel_src1, 0);
    check_eq("stall_only_cnt", stall_count, 2);

    // youngest writer wins; unused source never matches
    forward = 1'b1;
    drain();
    step(1, 1, 0, 4, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 4, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 4, 1, 0, 0, 0, 0);
    check_eq("youngest_sel1", sel_src1, 2);
    drain();
    step(1, 1, 0, 4, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 4, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 4, 0, 0, 0, 0, 0);
    check_eq("unused_sel1", sel_src1, 0);

    // flush during a load-use hazard
    drain();
    nop(1);
    step(1, 1, 1, 5, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 5, 1, 1, 0);
    check_eq("flush_stall", last_stall, 1);
    check_eq("flush_sel2", sel_src2, 0);
    check_eq("flush_cnt", stall_count, 0);

    // randomized traffic; a stalled ID instruction is held until it issues
    hold = 1'b0;
    r_v = 0; r_wb = 0; r_mem = 0; r_dest_v = 0; r_s1 = 0; r_u1 = 0; r_s2 = 0; r_u2 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        r_v      = ($urandom_range(0, 9) != 0);
        r_wb     = ($urandom_range(0, 3) != 0);
        r_mem    = ($urandom_range(0, 2) == 0);
        r_dest_v = $urandom_range(0, 3);
        r_s1     = $urandom_range(0, 3);
        r_u1     = ($urandom_range(0, 4) != 0);
        r_s2     = $urandom_range(0, 3);
        r_u2     = ($urandom_range(0, 1) != 0);
      end
      if ($urandom_range(0, 15) == 0) forward = ~forward;
      r_fl  = ($urandom_range(0, 9) == 0);
      r_clr = ($urandom_range(0, 63) == 0);
      step(r_v, r_wb, r_mem, r_dest_v, r_s1, r_u1, r_s2, r_u2, r_fl, r_clr);
      hold = last_stall && !r_fl;
    end

    // asynchronous reset mid-stream with a hazard pending
    forward = 1'b0;
    step(1, 1, 0, 3, 0, 0, 0, 0, 0, 0);
    issue_valid = 1'b1; id_src1 = 4'd3; id_src1_used = 1'b1; flush = 1'b0; stat_clr = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    check_eq("midrst_stall", stall, 0);
    check_eq("midrst_sel1", sel_src1, 0);
    check_eq("midrst_sel2", sel_src2, 0);
    check_eq("midrst_cnt", stall_count, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(1, 0, 0, 0, 3, 1, 0, 0, 0, 0);
    check_eq("postrst_stall", last_stall, 0);
    check_eq("postrst_sel1", sel_src1, 0);

    // saturation and clear
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
      consume(1, 1, 0, 0, ns);
    end
    check_eq("sat_cnt", stall_count, CNT_MAX);
    nop(1);
    check_eq("clr_cnt", stall_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
